simplified_fp_compare_pipe: RTL and testbench

Pipelined, parametrised comparator for the simplified sign-magnitude floating-point format: one sign bit, then an exponent field, then a fraction field, all magnitudes unsigned. It accepts one operand pair per cycle over a valid/ready handshake, resolves a selectable relation (GT/LT/GE/LE) plus the full GT/EQ/LT triple, and returns the selected operand (max or min). It sits between the operand-fetch stage and the sorting/threshold logic of the FP datapath, replacing single-cycle combinational compares where timing or backpressure matters.

---
 rtl/simplified_fp_compare_pipe.sv | 138 +++++++++++++
 tb/tb_simplified_fp_compare_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simplified_fp_compare_pipe.sv
// Two-stage sign-magnitude FP comparator.
// Returns GT/EQ/LT, a mode-selected flag and the max/min operand.
module simplified_fp_compare_pipe #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8,
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         gt,
  output logic         eq,
  output logic         lt,
  output logic         flag,
  output logic [W-1:0] result
);

  localparam int M = W - 1;

  logic         en;
  logic [M-1:0] ma;
  logic [M-1:0] mb;

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic [1:0]   s1_mode;
  logic         s1_sa;
  logic         s1_sb;
  logic         s1_mgt;
  logic         s1_meq;
  logic         s1_az;
  logic         s1_bz;

  logic         c_zz;
  logic         c_sd;
  logic         c_me;
  logic         c_mo;
  logic         n_gt;
  logic         n_eq;
  logic         n_lt;
  logic         n_flag;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign ma       = a[M-1:0];
  assign mb       = b[M-1:0];

  // Stage 1: capture operands and unsigned magnitude relations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
      s1_mgt   <= 1'b0;
      s1_meq   <= 1'b0;
      s1_az    <= 1'b0;
      s1_bz    <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_a     <= a;
      s1_b     <= b;
      s1_mode  <= mode;
      s1_sa    <= a[W-1];
      s1_sb    <= b[W-1];
      s1_mgt   <= ma > mb;
      s1_meq   <= ma == mb;
      s1_az    <= ma == '0;
      s1_bz    <= mb == '0;
    end
  end

  assign c_zz = s1_az & s1_bz;
  assign c_sd = ~c_zz & (s1_sa ^ s1_sb);
  assign c_me = ~c_zz & ~(s1_sa ^ s1_sb) & s1_meq;
  assign c_mo = ~c_zz & ~(s1_sa ^ s1_sb) & ~s1_meq;

  // Resolve signs against magnitude order; negatives reverse it.
  always_comb begin
    n_gt = 1'b0;
    n_eq = 1'b0;
    n_lt = 1'b0;
    unique case (1'b1)
      c_zz: n_eq = 1'b1;
      c_sd: begin
        n_gt = ~s1_sa;
        n_lt = s1_sa;
      end
      c_me: n_eq = 1'b1;
      c_mo: begin
        n_gt = s1_mgt ^ s1_sa;
        n_lt = ~(s1_mgt ^ s1_sa);
      end
      default: n_eq = 1'b0;
    endcase
  end

  // Relation selected by the mode captured with the pair.
  always_comb begin
    n_flag = 1'b0;
    unique case (s1_mode)
      2'b00: n_flag = n_gt;
      2'b01: n_flag = n_lt;
      2'b10: n_flag = n_gt | n_eq;
      2'b11: n_flag = n_lt | n_eq;
      default: n_flag = 1'b0;
    endcase
  end

  // Stage 2: result registers, frozen while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      flag      <= 1'b0;
      result    <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      gt        <= n_gt;
      eq        <= n_eq;
      lt        <= n_lt;
      flag      <= n_flag;
      result    <= n_flag ? s1_a : s1_b;
    end
  end

endmodule

// File: tb/tb_simplified_fp_compare_pipe.sv
// Randomized scoreboard bench for simplified_fp_compare_pipe.
// Reference compares operands as signed integers.
module tb_simplified_fp_compare_pipe;

  typedef struct {
    logic        gt;
    logic        eq;
    logic        lt;
    logic        flag;
    logic [31:0] res;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] a;
  logic [12:0] b;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic        gt;
  logic        eq;
  logic        lt;
  logic        flag;
  logic [12:0] result;

  logic        in_valid2;
  logic        in_ready2;
  logic [31:0] a2;
  logic [31:0] b2;
  logic [1:0]  mode2;
  logic        out_valid2;
  logic        gt2;
  logic        eq2;
  logic        lt2;
  logic        flag2;
  logic [31:0] result2;

  logic rnd_mode;
  logic rnd_rdy;
  logic dir_rdy;

  int nchk;
  int nerr;

  exp_t q[$];
  exp_t q2[$];

  assign out_ready = rnd_mode ? rnd_rdy : dir_rdy;

  simplified_fp_compare_pipe #(.EXP_W(4), .FRAC_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .eq(eq), .lt(lt), .flag(flag), .result(result)
  );

  simplified_fp_compare_pipe #(.EXP_W(8), .FRAC_W(23)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .mode(mode2),
    .out_valid(out_valid2), .out_ready(1'b1),
    .gt(gt2), .eq(eq2), .lt(lt2), .flag(flag2), .result(result2)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [1:0] m, input int w);
    exp_t   e;
    longint mx;
    longint my;
    longint vx;
    longint vy;
    mx = longint'(x) & ((64'sd1 <<< (w - 1)) - 1);
    my = longint'(y) & ((64'sd1 <<< (w - 1)) - 1);
    vx = x[w-1] ? -mx : mx;
    vy = y[w-1] ? -my : my;
    e.gt = vx > vy;
    e.eq = vx == vy;
    e.lt = vx < vy;
    case (m)
      2'b00:   e.flag = e.gt;
      2'b01:   e.flag = e.lt;
      2'b10:   e.flag = e.gt | e.eq;
      default: e.flag = e.lt | e.eq;
    endcase
    e.res = e.flag ? x : y;
    return e;
  endfunction

  task automatic send(input logic [12:0] ta, input logic [12:0] tb,
                      input logic [1:0] tm);
    int   n;
    logic ok;
    n = 0;
    ok = 1'b0;
    a = ta;
    b = tb;
    mode = tm;
    in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready && reset_n;
      if (ok) q.push_back(model({19'b0, ta}, {19'b0, tb}, tm, 13));
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL accept: pair a=%h not accepted within 100 cycles", ta);
    end
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [31:0] ta, input logic [31:0] tb,
                       input logic [1:0] tm);
    a2 = ta;
    b2 = tb;
    mode2 = tm;
    in_valid2 = 1'b1;
    @(negedge clk);
    nchk++;
    if (!in_ready2) begin
      nerr++;
      $display("FAIL accept32: in_ready=%b required 1", in_ready2);
    end else begin
      q2.push_back(model(ta, tb, tm, 32));
    end
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic        hold_armed;
  logic [17:0] hold_val;

  // Scoreboard monitor and stall-stability checks for the 13-bit unit.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      hold_armed = 1'b0;
    end else begin
      if (hold_armed) begin
        nchk++;
        if ({out_valid, gt, eq, lt, flag, result} != hold_val) begin
          nerr++;
          $display("FAIL hold: outputs %h changed during stall, required %h",
                   {out_valid, gt, eq, lt, flag, result}, hold_val);
        end
      end
      if (out_valid && !out_ready) begin
        nchk++;
        if (in_ready) begin
          nerr++;
          $display("FAIL stall_ready: in_ready=1 required 0");
        end
      end
      hold_armed = out_valid && !out_ready;
      hold_val = {out_valid, gt, eq, lt, flag, result};
      if (out_valid && out_ready) begin
        nchk++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected: result %h emitted, none expected", result);
        end else begin
          e = q.pop_front();
          if ({gt, eq, lt, flag} != {e.gt, e.eq, e.lt, e.flag} ||
              {19'b0, result} != e.res) begin
            nerr++;
            $display("FAIL result: got gt/eq/lt/flag=%b%b%b%b res=%h, required %b%b%b%b res=%h",
                     gt, eq, lt, flag, result, e.gt, e.eq, e.lt, e.flag, e.res[12:0]);
          end
        end
      end
    end
  end

  // Scoreboard monitor for the 32-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid2) begin
      nchk++;
      if (q2.size() == 0) begin
        nerr++;
        $display("FAIL unexpected32: result %h emitted, none expected", result2);
      end else begin
        e = q2.pop_front();
        if ({gt2, eq2, lt2, flag2} != {e.gt, e.eq, e.lt, e.flag} ||
            result2 != e.res) begin
          nerr++;
          $display("FAIL result32: got %b%b%b%b res=%h, required %b%b%b%b res=%h",
                   gt2, eq2, lt2, flag2, result2, e.gt, e.eq, e.lt, e.flag, e.res);
        end
      end
    end
  end

  // Random downstream readiness during the randomized phase.
  always @(posedge clk) begin
    #1;
    rnd_rdy = $urandom_range(0, 3) != 0;
  end

  function automatic logic [12:0] rnd_word();
    logic [12:0] v;
    v = 13'($urandom);
    if ($urandom_range(0, 5) == 0) v[11:0] = '0;
    return v;
  endfunction

  initial begin
    logic [12:0] ra;
    logic [12:0] rb;
    int          n;
    logic        seen;
    clk = 1'b0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    a = '0;
    b = '0;
    mode = '0;
    a2 = '0;
    b2 = '0;
    mode2 = '0;
    rnd_mode = 1'b0;
    rnd_rdy = 1'b1;
    dir_rdy = 1'b1;
    nchk = 0;
    nerr = 0;

    #2;
    nchk++;
    if ({out_valid, gt, eq, lt, flag, result, in_ready} != 19'h1) begin
      nerr++;
      $display("FAIL reset_state: outs=%h required 1",
               {out_valid, gt, eq, lt, flag, result, in_ready});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    send(13'h0380, 13'h1400, 2'b00);
    send(13'h1200, 13'h1380, 2'b01);
    send(13'h1200, 13'h1380, 2'b00);
    send(13'h0000, 13'h1000, 2'b10);
    send(13'h0000, 13'h1000, 2'b00);
    send(13'h1000, 13'h0000, 2'b11);
    send(13'h0123, 13'h0123, 2'b01);
    send(13'h1abc, 13'h1abc, 2'b11);
    idle(4);

    send2(32'h3F800000, 32'h40000000, 2'b11);
    send2(32'hBF800000, 32'hC0000000, 2'b00);
    send2(32'h80000000, 32'h00000000, 2'b00);
    send2(32'h7F7FFFFF, 32'hFF7FFFFF, 2'b01);
    idle(4);

    // Backpressure: four back-to-back pairs, stall three cycles.
    fork
      begin
        send(13'h0500, 13'h0400, 2'b00);
        send(13'h1500, 13'h1400, 2'b00);
        send(13'h0001, 13'h1001, 2'b11);
        send(13'h0fff, 13'h0ffe, 2'b10);
      end
      begin
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
          @(posedge clk);
          #1;
          seen = out_valid;
          n++;
        end
        nchk++;
        if (!seen) begin
          nerr++;
          $display("FAIL bp_wait: out_valid=0 after 20 cycles, required 1");
        end
        dir_rdy = 1'b0;
        idle(3);
        dir_rdy = 1'b1;
      end
    join
    idle(6);
    nchk++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL bp_drain: %0d results missing, required 0", q.size());
    end

    // Reset with two pairs in flight.
    dir_rdy = 1'b0;
    send(13'h0111, 13'h0222, 2'b00);
    send(13'h0333, 13'h0444, 2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    nchk++;
    if ({out_valid, gt, eq, lt, flag, result, in_ready} != 19'h1) begin
      nerr++;
      $display("FAIL mid_reset: outs=%h required 1",
               {out_valid, gt, eq, lt, flag, result, in_ready});
    end
    q.delete();
    dir_rdy = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(5);
    nchk++;
    if (out_valid) begin
      nerr++;
      $display("FAIL post_reset: out_valid=1 required 0");
    end

    // Randomized traffic with random backpressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = rnd_word();
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = {~ra[12], ra[11:0]};
        default: rb = rnd_word();
      endcase
      send(ra, rb, 2'($urandom));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rnd_mode = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    idle(2);
    nchk++;
    if (q.size() != 0 || q2.size() != 0) begin
      nerr++;
      $display("FAIL final_drain: %0d/%0d pending, required 0/0",
               q.size(), q2.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
